// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - forwarding select codes and pipeline stage structs
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // All-zero of every stage struct is the bubble: no write enables set.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } id_pipe_t;

  typedef struct packed {
    logic        we_reg;
    logic        we_dm;
    logic        hilo_we;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  waddr;
  } exe_pipe_t;

  typedef struct packed {
    logic        we_reg;
    logic        we_dm;
    logic        hilo_we;
    logic        mem_to_reg;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic [63:0] hilo;
    logic [4:0]  waddr;
  } mem_pipe_t;

  typedef struct packed {
    logic        we_reg;
    logic        hilo_we;
    logic        mem_to_reg;
    logic [31:0] alu_out;
    logic [31:0] rdata;
    logic [63:0] hilo;
    logic [4:0]  waddr;
  } wb_pipe_t;

  localparam int ID_PIPE_W  = $bits(id_pipe_t);
  localparam int EXE_PIPE_W = $bits(exe_pipe_t);
  localparam int MEM_PIPE_W = $bits(mem_pipe_t);
  localparam int WB_PIPE_W  = $bits(wb_pipe_t);

endpackage

// File: rtl/mux2.sv
// rtl/mux2.sv - two-way combinational operand select
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux3.sv
// rtl/mux3.sv - three-way forwarding select: register file, writeback, memory stage
module mux3
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  // The reserved code 2'b11 aliases the memory-stage forward.
  always_comb begin
    y = c;
    case (sel)
      FWD_RF:  y = a;
      FWD_WB:  y = b;
      FWD_MEM: y = c;
      default: y = c;
    endcase
  end

endmodule

// File: rtl/dreg.sv
// rtl/dreg.sv - pipeline stage register with stall (en) and flush (clr)
module dreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // A stall outranks a flush so a held instruction is never dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (clr) begin
        q <= '0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: tb/tb_dreg.sv
// tb/tb_dreg.sv - directed self-checking bench for dreg, mux2 and mux3
module tb_dreg;

  logic        clk;
  logic        rst, en, clr;
  logic [31:0] d, q;
  logic        rst64, en64, clr64;
  logic [63:0] d64, q64;
  logic        d1, q1;
  logic        sel2;
  logic [31:0] a2, b2, y2;
  logic [1:0]  sel3;
  logic [31:0] a3, b3, c3, y3;

  int vectors = 0;
  int miscompares = 0;

  dreg #(.WIDTH(32)) u_dut (.clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .q(q));
  dreg #(.WIDTH(64)) u_d64 (.clk(clk), .rst(rst64), .en(en64), .clr(clr64), .d(d64), .q(q64));
  dreg #(.WIDTH(1))  u_d1  (.clk(clk), .rst(rst64), .en(en64), .clr(clr64), .d(d1), .q(q1));
  mux2 #(.WIDTH(32)) u_m2 (.sel(sel2), .a(a2), .b(b2), .y(y2));
  mux3 #(.WIDTH(32)) u_m3 (.sel(sel3), .a(a3), .b(b3), .c(c3), .y(y3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        clr;
    logic [63:0] d64;
    logic        d1;
    logic [63:0] q64;
    logic        q1;
  } vec_t;

  vec_t vt[8];

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; d = 32'hDEADBEEF;
    rst64 = 1'b1; en64 = 1'b0; clr64 = 1'b0; d64 = '0; d1 = 1'b0;
    sel2 = 1'b0; a2 = '0; b2 = '0; sel3 = 2'b00; a3 = '0; b3 = '0; c3 = '0;

    // reset and release
    tick(); chk("reset", {32'h0, q}, 64'h0);
    rst = 1'b0;
    tick(); chk("post_reset_load", {32'h0, q}, 64'hDEADBEEF);

    // load then stall
    d = 32'h12345678;
    tick(); chk("load", {32'h0, q}, 64'h12345678);
    en = 1'b0; d = 32'hFFFFFFFF;
    tick(); chk("stall1", {32'h0, q}, 64'h12345678);
    tick(); chk("stall2", {32'h0, q}, 64'h12345678);
    tick(); chk("stall3", {32'h0, q}, 64'h12345678);
    en = 1'b1;
    tick(); chk("reenable", {32'h0, q}, 64'hFFFFFFFF);

    // flush versus stall
    d = 32'hA5A5A5A5;
    tick(); chk("load_a5", {32'h0, q}, 64'hA5A5A5A5);
    clr = 1'b1; d = 32'h1;
    tick(); chk("flush", {32'h0, q}, 64'h0);
    clr = 1'b0; d = 32'hA5A5A5A5;
    tick(); chk("reload_a5", {32'h0, q}, 64'hA5A5A5A5);
    en = 1'b0; clr = 1'b1;
    tick(); chk("stall_beats_flush", {32'h0, q}, 64'hA5A5A5A5);
    d = 'x;
    tick(); chk("x_blocked_stall", {32'h0, q}, 64'hA5A5A5A5);
    rst = 1'b1; clr = 1'b0;
    tick(); chk("reset_mid_stall", {32'h0, q}, 64'h0);
    rst = 1'b0; en = 1'b1; clr = 1'b1;
    tick(); chk("x_blocked_flush", {32'h0, q}, 64'h0);
    clr = 1'b0; d = 32'hCAFEF00D;
    tick(); chk("load_after_flush", {32'h0, q}, 64'hCAFEF00D);
    rst = 1'b1; en = 1'b1; clr = 1'b1;
    tick(); chk("reset_mid_flush", {32'h0, q}, 64'h0);
    rst = 1'b0; clr = 1'b0;

    // 64-bit and 1-bit instances under shared control, hand-computed
    vt[0] = '{1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 64'h8000000000000001, 1'b1, 64'h8000000000000001, 1'b1};
    vt[2] = '{1'b0, 1'b0, 1'b1, 64'h0,                1'b0, 64'h8000000000000001, 1'b1};
    vt[3] = '{1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b0, 64'h0000000000000123, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b1};
    vt[6] = '{1'b0, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b1, 64'h0123456789ABCDEF, 1'b1};
    vt[7] = '{1'b1, 1'b0, 1'b1, 64'h0,                1'b1, 64'h0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      rst64 = vt[i].rst; en64 = vt[i].en; clr64 = vt[i].clr;
      d64 = vt[i].d64; d1 = vt[i].d1;
      tick();
      chk($sformatf("w64_step%0d", i), q64, vt[i].q64);
      chk($sformatf("w1_step%0d", i), {63'h0, q1}, {63'h0, vt[i].q1});
    end

    // mux2
    a2 = 32'h11111111; b2 = 32'h22222222; sel2 = 1'b0;
    #1 chk("mux2_sel0", {32'h0, y2}, 64'h11111111);
    sel2 = 1'b1;
    #1 chk("mux2_sel1", {32'h0, y2}, 64'h22222222);
    a2 = 32'h33333333;
    #1 chk("mux2_a_change", {32'h0, y2}, 64'h22222222);
    b2 = 32'h44444444;
    #1 chk("mux2_b_change", {32'h0, y2}, 64'h44444444);

    // mux3
    a3 = 32'h0A; b3 = 32'h0B; c3 = 32'h0C; sel3 = 2'b00;
    #1 chk("mux3_rf", {32'h0, y3}, 64'h0A);
    sel3 = 2'b01;
    #1 chk("mux3_wb", {32'h0, y3}, 64'h0B);
    sel3 = 2'b10;
    #1 chk("mux3_mem", {32'h0, y3}, 64'h0C);
    sel3 = 2'b11;
    #1 chk("mux3_rsvd", {32'h0, y3}, 64'h0C);
    c3 = 32'h5C;
    #1 chk("mux3_c_change", {32'h0, y3}, 64'h5C);
    sel3 = 2'b00; a3 = 32'h7A;
    #1 chk("mux3_a_change", {32'h0, y3}, 64'h7A);
    sel3 = 2'b01; b3 = 32'h9B;
    #1 chk("mux3_b_change", {32'h0, y3}, 64'h9B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
